// File: rtl/dff_simple.sv
// dff_simple: positive-edge D flip-flop with asynchronous active-low reset.
// One flat register of WIDTH bits; q loads RESET_VAL while reset_n is low
// and otherwise samples d only on a rising clk edge. No power-up value is
// given, so q is unknown until the first reset or clock edge.
module dff_simple #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage: reset overrides everything, including a coincident clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_dff_simple.sv
// tb_dff_simple: directed, table-driven checks of dff_simple.
// A 1-bit instance is walked through a vector table where each record sets
// reset_n, clk and d, then q is sampled 1 time unit later. An 8-bit instance
// with a non-zero reset value is checked with a short hand-written sequence.
module tb_dff_simple;

  typedef struct {
    logic        rn;
    logic        ck;
    logic        d;
    logic        exp_q;
    logic [63:0] name;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // 1-bit instance signals
  logic       clk1;
  logic       rn1;
  logic [0:0] d1;
  logic [0:0] q1;

  // 8-bit instance signals
  logic       clk8;
  logic       rn8;
  logic [7:0] d8;
  logic [7:0] q8;

  dff_simple #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_dut1 (
    .clk     (clk1),
    .reset_n (rn1),
    .d       (d1),
    .q       (q1)
  );

  dff_simple #(
    .WIDTH     (8),
    .RESET_VAL (8'hA5)
  ) u_dut8 (
    .clk     (clk8),
    .reset_n (rn8),
    .d       (d8),
    .q       (q8)
  );

  vec_t vq[$];

  function automatic vec_t mk(input logic rn, input logic ck, input logic d,
                              input logic exp_q, input logic [63:0] name);
    vec_t v;
    v.rn    = rn;
    v.ck    = ck;
    v.d     = d;
    v.exp_q = exp_q;
    v.name  = name;
    return v;
  endfunction

  task automatic check8(input logic [63:0] name, input logic [7:0] exp_q);
    n_cmp++;
    if (q8 !== exp_q) begin
      n_err++;
      $display("FAIL %s: q=%h expected %h", name, q8, exp_q);
    end
  endtask

  // Drive one 8-bit step, then sample 1 time unit later.
  task automatic step8(input logic rn, input logic ck, input logic [7:0] d,
                       input logic [7:0] exp_q, input logic [63:0] name);
    d8   = d;
    rn8  = rn;
    clk8 = ck;
    #1;
    check8(name, exp_q);
    #4;
  endtask

  initial begin
    clk1 = 1'b0; rn1 = 1'b1; d1 = 1'b0;
    clk8 = 1'b0; rn8 = 1'b1; d8 = 8'h00;

    // Reset with clk low, then a clock edge while still in reset
    vq.push_back(mk(0, 0, 1, 0, "rst_low"));
    vq.push_back(mk(0, 1, 1, 0, "rst_edge"));
    vq.push_back(mk(0, 0, 1, 0, "rst_fall"));
    vq.push_back(mk(1, 0, 0, 0, "rst_rel"));
    // Capture sequence
    vq.push_back(mk(1, 1, 0, 0, "cap_d0"));
    vq.push_back(mk(1, 0, 1, 0, "lowd1"));
    vq.push_back(mk(1, 1, 1, 1, "cap_d1"));
    vq.push_back(mk(1, 0, 0, 1, "hold1"));
    vq.push_back(mk(1, 1, 0, 0, "cap_d0b"));
    vq.push_back(mk(1, 0, 0, 0, "fall0"));
    // Opaque with clk held low
    vq.push_back(mk(1, 0, 1, 0, "opl_1"));
    vq.push_back(mk(1, 0, 1, 0, "opl_2"));
    vq.push_back(mk(1, 0, 0, 0, "opl_3"));
    vq.push_back(mk(1, 0, 1, 0, "opl_4"));
    vq.push_back(mk(1, 0, 1, 0, "opl_5"));
    vq.push_back(mk(1, 0, 0, 0, "opl_6"));
    // Opaque with clk held high (first record is the rising edge, d=0)
    vq.push_back(mk(1, 1, 0, 0, "oph_1"));
    vq.push_back(mk(1, 1, 1, 0, "oph_2"));
    vq.push_back(mk(1, 1, 0, 0, "oph_3"));
    vq.push_back(mk(1, 1, 1, 0, "oph_4"));
    vq.push_back(mk(1, 1, 1, 0, "oph_5"));
    vq.push_back(mk(1, 1, 0, 0, "oph_6"));
    vq.push_back(mk(1, 0, 1, 0, "oph_fall"));
    // Mid-operation reset between edges
    vq.push_back(mk(1, 1, 1, 1, "mid_cap1"));
    vq.push_back(mk(1, 0, 1, 1, "mid_low"));
    vq.push_back(mk(0, 0, 1, 0, "mid_rst"));
    vq.push_back(mk(1, 0, 1, 0, "mid_rel"));
    vq.push_back(mk(1, 1, 1, 1, "mid_cap"));
    // Reset and rising clock in the same instant: reset wins
    vq.push_back(mk(1, 0, 1, 1, "sim_pre"));
    vq.push_back(mk(0, 1, 1, 0, "sim_rst"));
    vq.push_back(mk(1, 0, 1, 0, "sim_rel"));
    vq.push_back(mk(1, 1, 1, 1, "sim_cap"));

    #5;
    foreach (vq[i]) begin
      d1   = vq[i].d;
      rn1  = vq[i].rn;
      clk1 = vq[i].ck;
      #1;
      n_cmp++;
      if (q1 !== vq[i].exp_q) begin
        n_err++;
        $display("FAIL %s (vec %0d): q=%b expected %b", vq[i].name, i, q1, vq[i].exp_q);
      end
      #4;
    end

    // 8-bit instance with RESET_VAL = 8'hA5
    step8(0, 0, 8'h00, 8'hA5, "w_rst");
    step8(0, 1, 8'h3C, 8'hA5, "w_rsteg");
    step8(0, 0, 8'h3C, 8'hA5, "w_rstlo");
    step8(1, 0, 8'h3C, 8'hA5, "w_rel");
    step8(1, 1, 8'h3C, 8'h3C, "w_cap");
    step8(1, 0, 8'hFF, 8'h3C, "w_lowd");
    step8(1, 1, 8'hFF, 8'hFF, "w_cap2");
    step8(1, 1, 8'h00, 8'hFF, "w_high");
    step8(1, 0, 8'h00, 8'hFF, "w_fall");
    step8(0, 0, 8'h00, 8'hA5, "w_mrst");
    step8(1, 0, 8'h5A, 8'hA5, "w_mrel");
    step8(1, 1, 8'h5A, 8'h5A, "w_cap3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
